ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_sync_filter.sv | 57 +++++
 rtl/ps2_host_tx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: default line timing and host-transmit state encoding.
// Used by the host transmitter and the keyboard receiver.
package ps2_pkg;

    localparam int unsigned PS2_CLK_HZ     = 100_000_000;
    localparam int unsigned PS2_INHIBIT_US = 120;
    localparam int unsigned PS2_TIMEOUT_US = 15_000;
    localparam int unsigned PS2_FILT_LEN   = 8;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        BITS,
        ACK,
        RELEASE
    } ps2_tx_state_e;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// PS/2 line conditioning: 2-FF synchronizers on clock and data, clock glitch
// filter with a one-cycle falling-edge pulse aligned to the filtered level.
module ps2_sync_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILT_LEN = PS2_FILT_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_clk_filt,
    output logic o_data_sync,
    output logic o_clk_fall
);

    localparam int unsigned CW = $clog2(FILT_LEN + 1);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic          r_clk_filt;
    logic          r_fall;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_flip;

    // Level flips only once the synced clock has disagreed FILT_LEN times in a row
    assign w_diff = r_clk_sync[1] != r_clk_filt;
    assign w_flip = w_diff && (r_cnt == CW'(FILT_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_filt  <= 1'b1;
            r_fall      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_fall      <= w_flip && r_clk_filt;
            if (w_flip) begin
                r_clk_filt <= ~r_clk_filt;
            end
            if (!w_diff || w_flip) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_clk_filt  = r_clk_filt;
    assign o_data_sync = r_data_sync[1];
    assign o_clk_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift
// 8 data bits + odd parity on device clock falls, check the device ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ      = PS2_CLK_HZ,
    parameter int unsigned INHIBIT_CYC = CLK_HZ / 1_000_000 * PS2_INHIBIT_US,
    parameter int unsigned TIMEOUT_CYC = CLK_HZ / 1_000_000 * PS2_TIMEOUT_US,
    parameter int unsigned FILT_LEN    = PS2_FILT_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned CW = $clog2(INHIBIT_CYC + TIMEOUT_CYC + 2);

    ps2_tx_state_e r_state;
    ps2_tx_state_e w_state_n;
    logic [7:0]    r_data;
    logic [7:0]    w_data_n;
    logic          r_par;
    logic          w_par_n;
    logic [3:0]    r_bit;
    logic [3:0]    w_bit_n;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_n;
    logic          r_ack;
    logic          w_ack_n;
    logic          r_clk_oe;
    logic          w_clk_oe_n;
    logic          r_data_oe;
    logic          w_data_oe_n;
    logic          r_done;
    logic          w_done_n;
    logic          r_err;
    logic          w_err_n;
    logic          w_clk_filt;
    logic          w_data_sync;
    logic          w_fall;
    logic          w_waiting;

    ps2_sync_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_sync (
        .clk         (clk),
        .rst         (rst),
        .i_ps2_clk   (ps2_clk_in),
        .i_ps2_data  (ps2_data_in),
        .o_clk_filt  (w_clk_filt),
        .o_data_sync (w_data_sync),
        .o_clk_fall  (w_fall)
    );

    assign w_waiting = (r_state != IDLE) && (r_state != INHIBIT);

    always_comb begin
        w_state_n   = r_state;
        w_data_n    = r_data;
        w_par_n     = r_par;
        w_bit_n     = r_bit;
        w_cnt_n     = r_cnt + 1'b1;
        w_ack_n     = r_ack;
        w_clk_oe_n  = r_clk_oe;
        w_data_oe_n = r_data_oe;
        w_done_n    = 1'b0;
        w_err_n     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_n     = '0;
                w_clk_oe_n  = 1'b0;
                w_data_oe_n = 1'b0;
                if (tx_valid) begin
                    w_data_n   = tx_data;
                    w_par_n    = odd_parity(tx_data);
                    w_clk_oe_n = 1'b1;
                    w_state_n  = INHIBIT;
                end
            end
            INHIBIT: begin
                // Start bit goes out for one cycle while clock is still held low
                if (r_cnt == CW'(INHIBIT_CYC - 1)) begin
                    w_data_oe_n = 1'b1;
                end else if (r_cnt == CW'(INHIBIT_CYC)) begin
                    w_clk_oe_n = 1'b0;
                    w_cnt_n    = '0;
                    w_bit_n    = '0;
                    w_state_n  = START;
                end
            end
            START, BITS: begin
                if (w_fall) begin
                    w_cnt_n   = '0;
                    w_bit_n   = r_bit + 1'b1;
                    w_state_n = BITS;
                    if (r_bit < 4'd8) begin
                        w_data_oe_n = ~r_data[r_bit[2:0]];
                    end else if (r_bit == 4'd8) begin
                        w_data_oe_n = ~r_par;
                    end else begin
                        w_data_oe_n = 1'b0;
                        w_state_n   = ACK;
                    end
                end
            end
            ACK: begin
                if (w_fall) begin
                    w_cnt_n   = '0;
                    w_ack_n   = ~w_data_sync;
                    w_state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (w_clk_filt && w_data_sync) begin
                    w_done_n  = r_ack;
                    w_err_n   = ~r_ack;
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
        // A silent device aborts the transfer from any clocked phase
        if (w_waiting && !w_fall && r_cnt == CW'(TIMEOUT_CYC - 1)) begin
            w_state_n   = IDLE;
            w_cnt_n     = '0;
            w_clk_oe_n  = 1'b0;
            w_data_oe_n = 1'b0;
            w_done_n    = 1'b0;
            w_err_n     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_data    <= '0;
            r_par     <= 1'b1;
            r_bit     <= '0;
            r_cnt     <= '0;
            r_ack     <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_data    <= w_data_n;
            r_par     <= w_par_n;
            r_bit     <= w_bit_n;
            r_cnt     <= w_cnt_n;
            r_ack     <= w_ack_n;
            r_clk_oe  <= w_clk_oe_n;
            r_data_oe <= w_data_oe_n;
            r_done    <= w_done_n;
            r_err     <= w_err_n;
        end
    end

    assign tx_ready    = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign done        = r_done;
    assign err         = r_err;

endmodule
